// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: branch redirect, load-use stall insertion and
// saturating performance counters for the five-stage RISC-V core.
module hazard_ctrl #(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_PCSrc,
    input  logic             i_idex_MemRead,
    input  logic [4:0]       i_idex_rd,
    input  logic [4:0]       i_ifid_rs1,
    input  logic [4:0]       i_ifid_rs2,
    input  logic             i_ifid_use_rs1,
    input  logic             i_ifid_use_rs2,
    output logic             o_pc_write,
    output logic             o_pc_sel,
    output logic             o_ifid_write,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_exmem_flush,
    output logic             o_stalling,
    output logic [CNT_W-1:0] o_taken_cnt,
    output logic [CNT_W-1:0] o_stall_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    // The hazard cycle itself is the first stall cycle, so the counter is
    // loaded with the number of extra cycles minus one.
    localparam logic [2:0]       STALL_INIT = (LOAD_LAT > 1) ? 3'(LOAD_LAT - 2) : 3'd0;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state;
    logic [2:0]       scnt;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] stall_cnt;

    logic haz;
    logic redirect;
    logic stall_mode;

    assign haz = i_idex_MemRead && (i_idex_rd != 5'd0) &&
                 ((i_ifid_use_rs1 && (i_idex_rd == i_ifid_rs1)) ||
                  (i_ifid_use_rs2 && (i_idex_rd == i_ifid_rs2)));

    assign redirect   = i_PCSrc;
    assign stall_mode = !i_PCSrc && ((state == STALL) || haz);

    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // if/else chain can leave one unassigned and infer a latch.
        o_pc_write    = 1'b1;
        o_pc_sel      = 1'b0;
        o_ifid_write  = 1'b1;
        o_ifid_flush  = 1'b0;
        o_idex_flush  = 1'b0;
        o_exmem_flush = 1'b0;
        o_stalling    = 1'b0;
        if (i_rst) begin
            o_pc_write    = 1'b0;
            o_ifid_write  = 1'b0;
            o_ifid_flush  = 1'b1;
            o_idex_flush  = 1'b1;
            o_exmem_flush = 1'b1;
        end else if (redirect) begin
            o_pc_sel      = 1'b1;
            o_ifid_write  = 1'b0;
            o_ifid_flush  = 1'b1;
            o_idex_flush  = 1'b1;
            o_exmem_flush = 1'b1;
        end else if (stall_mode) begin
            o_pc_write    = 1'b0;
            o_ifid_write  = 1'b0;
            o_idex_flush  = 1'b1;
            o_stalling    = 1'b1;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= RUN;
            scnt      <= 3'd0;
            taken_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    // With LOAD_LAT==1 the hazard drops by itself once the load leaves EX.
                    if (!redirect && haz && (LOAD_LAT > 1)) begin
                        state <= STALL;
                        scnt  <= STALL_INIT;
                    end
                end
                STALL: begin
                    if (redirect) begin
                        state <= RUN;
                        scnt  <= 3'd0;
                    end else if (scnt == 3'd0) begin
                        state <= RUN;
                    end else begin
                        scnt <= scnt - 3'd1;
                    end
                end
                default: begin
                    state <= RUN;
                    scnt  <= 3'd0;
                end
            endcase

            if (redirect && (taken_cnt != CNT_MAX))
                taken_cnt <= taken_cnt + CNT_W'(1);
            if (stall_mode && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign o_taken_cnt = taken_cnt;
    assign o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: two instances (LOAD_LAT=1/CNT_W=4 and
// LOAD_LAT=3/CNT_W=32) share stimulus; a scoreboard carries expected outputs.
module tb_hazard_ctrl;

    localparam int A_LAT = 1;
    localparam int A_W   = 4;
    localparam int B_LAT = 3;
    localparam int B_W   = 32;

    localparam logic [6:0] C_RST    = 7'b000_111_0;
    localparam logic [6:0] C_REDIR  = 7'b110_111_0;
    localparam logic [6:0] C_STALL  = 7'b000_010_1;
    localparam logic [6:0] C_NORMAL = 7'b101_000_0;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic       i_rst, i_PCSrc, i_idex_MemRead, i_ifid_use_rs1, i_ifid_use_rs2;
    logic [4:0] i_idex_rd, i_ifid_rs1, i_ifid_rs2;

    logic pc_write_a, pc_sel_a, ifid_write_a, ifid_flush_a, idex_flush_a, exmem_flush_a, stalling_a;
    logic pc_write_b, pc_sel_b, ifid_write_b, ifid_flush_b, idex_flush_b, exmem_flush_b, stalling_b;
    logic [A_W-1:0] taken_a, stall_a;
    logic [B_W-1:0] taken_b, stall_b;
    logic [6:0] ctrl_a, ctrl_b, obs_ctrl_a, obs_ctrl_b;

    assign ctrl_a = {pc_write_a, pc_sel_a, ifid_write_a, ifid_flush_a, idex_flush_a, exmem_flush_a, stalling_a};
    assign ctrl_b = {pc_write_b, pc_sel_b, ifid_write_b, ifid_flush_b, idex_flush_b, exmem_flush_b, stalling_b};

    hazard_ctrl #(.LOAD_LAT(A_LAT), .CNT_W(A_W)) u_a (
        .i_clk(i_clk), .i_rst(i_rst), .i_PCSrc(i_PCSrc), .i_idex_MemRead(i_idex_MemRead),
        .i_idex_rd(i_idex_rd), .i_ifid_rs1(i_ifid_rs1), .i_ifid_rs2(i_ifid_rs2),
        .i_ifid_use_rs1(i_ifid_use_rs1), .i_ifid_use_rs2(i_ifid_use_rs2),
        .o_pc_write(pc_write_a), .o_pc_sel(pc_sel_a), .o_ifid_write(ifid_write_a),
        .o_ifid_flush(ifid_flush_a), .o_idex_flush(idex_flush_a), .o_exmem_flush(exmem_flush_a),
        .o_stalling(stalling_a), .o_taken_cnt(taken_a), .o_stall_cnt(stall_a)
    );

    hazard_ctrl #(.LOAD_LAT(B_LAT), .CNT_W(B_W)) u_b (
        .i_clk(i_clk), .i_rst(i_rst), .i_PCSrc(i_PCSrc), .i_idex_MemRead(i_idex_MemRead),
        .i_idex_rd(i_idex_rd), .i_ifid_rs1(i_ifid_rs1), .i_ifid_rs2(i_ifid_rs2),
        .i_ifid_use_rs1(i_ifid_use_rs1), .i_ifid_use_rs2(i_ifid_use_rs2),
        .o_pc_write(pc_write_b), .o_pc_sel(pc_sel_b), .o_ifid_write(ifid_write_b),
        .o_ifid_flush(ifid_flush_b), .o_idex_flush(idex_flush_b), .o_exmem_flush(exmem_flush_b),
        .o_stalling(stalling_b), .o_taken_cnt(taken_b), .o_stall_cnt(stall_b)
    );

    typedef struct {
        logic            st;
        int              scnt;
        longint unsigned taken;
        longint unsigned stalls;
    } model_t;

    typedef struct {
        logic [6:0]      ctrl_a, ctrl_b;
        longint unsigned taken_a, stall_a, taken_b, stall_b;
    } exp_t;

    model_t ma, mb;
    exp_t   sb[$];
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic calc_haz();
        return i_idex_MemRead && (i_idex_rd != 5'd0) &&
               ((i_ifid_use_rs1 && (i_idex_rd == i_ifid_rs1)) ||
                (i_ifid_use_rs2 && (i_idex_rd == i_ifid_rs2)));
    endfunction

    function automatic logic [6:0] model_ctrl(model_t m, logic rst, logic pcsrc, logic haz);
        if (rst)               return C_RST;
        if (pcsrc)             return C_REDIR;
        if (m.st || haz)       return C_STALL;
        return C_NORMAL;
    endfunction

    function automatic model_t model_next(model_t m, int lat, longint unsigned maxv,
                                          logic rst, logic pcsrc, logic haz);
        model_t n = m;
        if (rst) begin
            n.st = 1'b0; n.scnt = 0; n.taken = 0; n.stalls = 0;
            return n;
        end
        if (pcsrc && m.taken < maxv) n.taken = m.taken + 1;
        if (!pcsrc && (m.st || haz) && m.stalls < maxv) n.stalls = m.stalls + 1;
        if (!m.st) begin
            if (!pcsrc && haz && lat > 1) begin
                n.st = 1'b1; n.scnt = lat - 2;
            end
        end else if (pcsrc) begin
            n.st = 1'b0; n.scnt = 0;
        end else if (m.scnt == 0) begin
            n.st = 1'b0;
        end else begin
            n.scnt = m.scnt - 1;
        end
        return n;
    endfunction

    // One clock cycle: drive at posedge+1, compare at negedge, advance models.
    task automatic step(input logic rst, input logic pcsrc, input logic memread,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic use1, input logic use2);
        exp_t e;
        logic h;
        i_rst = rst; i_PCSrc = pcsrc; i_idex_MemRead = memread;
        i_idex_rd = rd; i_ifid_rs1 = rs1; i_ifid_rs2 = rs2;
        i_ifid_use_rs1 = use1; i_ifid_use_rs2 = use2;
        h = calc_haz();
        e.ctrl_a  = model_ctrl(ma, rst, pcsrc, h);
        e.ctrl_b  = model_ctrl(mb, rst, pcsrc, h);
        e.taken_a = ma.taken; e.stall_a = ma.stalls;
        e.taken_b = mb.taken; e.stall_b = mb.stalls;
        sb.push_back(e);
        @(negedge i_clk);
        e = sb.pop_front();
        check("ctrl_a",  64'(ctrl_a),  64'(e.ctrl_a));
        check("ctrl_b",  64'(ctrl_b),  64'(e.ctrl_b));
        check("taken_a", 64'(taken_a), e.taken_a);
        check("stall_a", 64'(stall_a), e.stall_a);
        check("taken_b", 64'(taken_b), e.taken_b);
        check("stall_b", 64'(stall_b), e.stall_b);
        obs_ctrl_a = ctrl_a;
        obs_ctrl_b = ctrl_b;
        ma = model_next(ma, A_LAT, (64'd1 << A_W) - 1, rst, pcsrc, h);
        mb = model_next(mb, B_LAT, (64'd1 << B_W) - 1, rst, pcsrc, h);
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic load_use();
        step(1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1);
    endtask

    initial begin
        ma = '{st: 1'b0, scnt: 0, taken: 0, stalls: 0};
        mb = ma;
        i_rst = 1'b1; i_PCSrc = 1'b0; i_idex_MemRead = 1'b0;
        i_idex_rd = '0; i_ifid_rs1 = '0; i_ifid_rs2 = '0;
        i_ifid_use_rs1 = 1'b0; i_ifid_use_rs2 = 1'b0;
        @(posedge i_clk);
        #1;

        // Reset held for two cycles, then NORMAL.
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        check("rst_ctrl", 64'(obs_ctrl_a), 64'(C_RST));
        idle();
        check("norm_ctrl", 64'(obs_ctrl_a), 64'(C_NORMAL));
        check("norm_taken", 64'(taken_a), 64'd0);

        // Taken branch.
        step(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        check("redir_ctrl", 64'(obs_ctrl_a), 64'(C_REDIR));
        check("redir_cnt", 64'(taken_a), 64'd1);
        idle();
        check("after_redir", 64'(obs_ctrl_a), 64'(C_NORMAL));

        // Load-use: one stall on the LOAD_LAT=1 instance, three on LOAD_LAT=3.
        load_use();
        check("lu_ctrl_a", 64'(obs_ctrl_a), 64'(C_STALL));
        idle();
        check("lu_cnt_a", 64'(stall_a), 64'd1);
        check("lu_norm_a", 64'(obs_ctrl_a), 64'(C_NORMAL));
        check("lu_hold_b", 64'(obs_ctrl_b), 64'(C_STALL));
        idle();
        check("lu_cnt_b", 64'(stall_b), 64'd3);
        idle();
        check("lu_end_b", 64'(obs_ctrl_b), 64'(C_NORMAL));

        // rd == x0 never stalls.
        step(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        check("rd0_ctrl", 64'(obs_ctrl_a), 64'(C_NORMAL));
        check("rd0_cnt", 64'(stall_a), 64'd1);

        // Redirect beats a simultaneous hazard.
        step(1'b0, 1'b1, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1);
        check("prio_ctrl", 64'(obs_ctrl_b), 64'(C_REDIR));
        check("prio_stall", 64'(stall_b), 64'd3);

        // Redirect in the second stall cycle aborts the stall.
        load_use();
        step(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        check("abort_ctrl", 64'(obs_ctrl_b), 64'(C_REDIR));
        idle();
        check("abort_norm", 64'(obs_ctrl_b), 64'(C_NORMAL));
        check("abort_cnt", 64'(stall_b), 64'd4);

        // Saturation of the 4-bit taken counter.
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        check("sat_taken", 64'(taken_a), 64'd15);
        check("sat_taken_b", 64'(taken_b), 64'd23);

        // Reset asserted mid-stall.
        load_use();
        idle();
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        check("mrst_stall", 64'(stall_b), 64'd0);
        check("mrst_taken", 64'(taken_a), 64'd0);
        idle();
        check("mrst_norm", 64'(obs_ctrl_b), 64'(C_NORMAL));

        // Random traffic with a small register set to provoke matches.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
